// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_pkg
// Brief   : Shared op encodings, FSM state encoding and helpers for the
//           HI/LO multiply/divide sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned c_WIDTH_DEFAULT = 32;

  // EX-stage operation codes; 6 and 7 are not requests
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_RUN = 3'd2,
    S_DIV_FIX = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Multiply and divide ops occupy the pipeline for more than one cycle
  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_div_restoring.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_div_restoring
// Brief   : Iterative unsigned restoring divider, one quotient bit per cycle.
//           A zero divisor yields an all-ones quotient and the dividend as
//           remainder without any special casing.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl_div_restoring #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int c_CNT_W = $clog2(DIV_CYCLES + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_run;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_div};
  assign w_borrow = w_diff[WIDTH];

  // Load operands on start, then shift/subtract once per cycle until the count expires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (abort_i) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start_i) begin
      r_cnt <= c_CNT_W'(DIV_CYCLES);
      r_run <= 1'b1;
      r_rem <= '0;
      r_quo <= dividend_i;
      r_div <= divisor_i;
    end else if (r_run) begin
      r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (r_cnt == c_CNT_W'(1)) begin
        r_run <= 1'b0;
      end
    end
  end

  // done_o marks the cycle whose edge retires the final quotient bit
  assign done_o      = r_run && (r_cnt == c_CNT_W'(1));
  assign quotient_o  = r_quo;
  assign remainder_o = r_rem;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl
// Brief   : Sequencer owning all HI/LO writes: single-cycle multiply,
//           iterative restoring divide, MTHI/MTLO, pipeline stall and a
//           single write pulse per completed operation.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH      = c_WIDTH_DEFAULT,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             r_state;
  logic               r_busy;
  logic               r_we;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_mul_signed;
  logic               r_q_neg;
  logic               r_r_neg;

  logic               w_accept;
  logic               w_div_start;
  logic               w_div_abort;
  logic               w_div_done;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept    = (r_state == S_IDLE) && start_i && !cancel_i && op_is_legal(op_i);
  assign w_div_start = w_accept && ((op_i == OP_DIV) || (op_i == OP_DIVU));
  assign w_div_abort = cancel_i && (r_state != S_IDLE) && (r_state != S_DONE);

  // Signed divide works on magnitudes; signs are reapplied in DIV_FIX
  assign w_a_neg = (op_i == OP_DIV) && a_i[WIDTH-1];
  assign w_b_neg = (op_i == OP_DIV) && b_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;

  // One 2W-bit multiplier serves both forms; the low 2W bits of a product of
  // sign-extended operands equal the signed product.
  assign w_mul_a = r_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_mul_b = r_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  hilo_muldiv_ctrl_div_restoring #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (w_div_start),
    .abort_i     (w_div_abort),
    .dividend_i  (w_a_mag),
    .divisor_i   (w_b_mag),
    .quotient_o  (w_quo),
    .remainder_o (w_rem),
    .done_o      (w_div_done)
  );

  // Control FSM with registered busy, write strobe and write data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_we         <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_mul_signed <= 1'b0;
      r_q_neg      <= 1'b0;
      r_r_neg      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= a_i;
            r_b          <= b_i;
            r_mul_signed <= (op_i == OP_MULT);
            r_q_neg      <= w_a_neg ^ w_b_neg;
            r_r_neg      <= w_a_neg;
            r_busy       <= 1'b1;
            case (op_i)
              OP_MULT, OP_MULTU: r_state <= S_MUL;
              OP_DIV, OP_DIVU:   r_state <= S_DIV_RUN;
              OP_MTHI: begin
                r_hi    <= a_i;
                r_lo    <= lo_i;
                r_we    <= 1'b1;
                r_state <= S_DONE;
              end
              default: begin
                r_hi    <= hi_i;
                r_lo    <= a_i;
                r_we    <= 1'b1;
                r_state <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          if (cancel_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            {r_hi, r_lo} <= w_prod;
            r_we         <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DIV_RUN: begin
          if (cancel_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_div_done) begin
            r_state <= S_DIV_FIX;
          end
        end
        S_DIV_FIX: begin
          if (cancel_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_lo    <= r_q_neg ? -w_quo : w_quo;
            r_hi    <= r_r_neg ? -w_rem : w_rem;
            r_we    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers multi-cycle work; DONE releases EX as the write lands
  assign stall_o = (r_state == S_MUL) || (r_state == S_DIV_RUN) || (r_state == S_DIV_FIX) ||
                   ((r_state == S_IDLE) && start_i && op_is_muldiv(op_i));

  assign busy_o    = r_busy;
  assign hilo_we_o = r_we;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_muldiv_ctrl
// Brief   : Self-checking bench for hilo_muldiv_ctrl: directed and random
//           ops against an arithmetic reference model, plus cancel/reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int c_W   = 32;
  localparam int c_DIV = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic [2:0]     op_i;
  logic [c_W-1:0] a_i;
  logic [c_W-1:0] b_i;
  logic           cancel_i;
  logic [c_W-1:0] hi_i;
  logic [c_W-1:0] lo_i;
  logic           stall_o;
  logic           busy_o;
  logic           hilo_we_o;
  logic [c_W-1:0] hi_o;
  logic [c_W-1:0] lo_o;

  int n_pass  = 0;
  int n_total = 0;
  int we_count = 0;
  int we_exp   = 0;

  hilo_muldiv_ctrl #(
    .WIDTH      (c_W),
    .DIV_CYCLES (c_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .cancel_i  (cancel_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write pulse seen on the HI/LO port
  always @(negedge clk) begin
    if (hilo_we_o === 1'b1) we_count++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: results from plain arithmetic on the architectural rules
  task automatic model(input logic [2:0] op, input logic [31:0] a, b, hin, lin,
                       output logic [31:0] ehi, elo, output int lat);
    longint unsigned ma, mb, q, r;
    logic [63:0]     p;
    bit              sa, sb;
    ehi = '0; elo = '0; lat = 0;
    case (op)
      OP_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        ehi = p[63:32]; elo = p[31:0]; lat = 2;
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        ehi = p[63:32]; elo = p[31:0]; lat = 2;
      end
      OP_DIV, OP_DIVU: begin
        sa = (op == OP_DIV) && a[31];
        sb = (op == OP_DIV) && b[31];
        ma = sa ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
        mb = sb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
        if (mb == 0) begin q = 64'hFFFF_FFFF; r = ma; end
        else begin q = ma / mb; r = ma % mb; end
        elo = (sa ^ sb) ? 32'(64'd0 - q) : 32'(q);
        ehi = sa ? 32'(64'd0 - r) : 32'(r);
        lat = c_DIV + 2;
      end
      OP_MTHI: begin ehi = a;   elo = lin; lat = 1; end
      OP_MTLO: begin ehi = hin; elo = a;   lat = 1; end
      default: lat = 0;
    endcase
  endtask

  // Issue one op at a negedge and check stall, latency, data and return to idle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, hin, lin);
    logic [31:0] ehi, elo;
    int lat, got_lat, stall_err;
    bit md;
    model(op, a, b, hin, lin, ehi, elo, lat);
    md = (op <= 3'd3);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; hi_i = hin; lo_i = lin;
    #1;
    chk("stall_accept", stall_o, md);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; hi_i = $urandom; lo_i = $urandom;
    #1;
    got_lat = 0; stall_err = 0;
    for (int c = 1; c <= c_DIV + 10; c++) begin
      if (stall_o !== (md && (c < lat))) stall_err++;
      if (hilo_we_o === 1'b1) begin got_lat = c; break; end
      @(negedge clk);
    end
    we_exp++;
    chk("latency", got_lat, lat);
    chk("stall_seq", stall_err, 0);
    chk("hi", hi_o, ehi);
    chk("lo", lo_o, elo);
    @(negedge clk);
    chk("idle_after", {hilo_we_o, busy_o, stall_o}, 3'b000);
  endtask

  initial begin
    int base;
    logic [31:0] ra, rb;
    rst = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    cancel_i = 1'b0; hi_i = '0; lo_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy_o, hilo_we_o, stall_o}, 3'b000);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    run_op(OP_MTHI, 32'h1234_5678, 32'h0, 32'h0, 32'hAAAA_5555);
    run_op(OP_MTLO, 32'h8765_4321, 32'h0, 32'hC3C3_3C3C, 32'h0);
    run_op(OP_DIVU, 32'h55, 32'h0, 32'h0, 32'h0);
    run_op(OP_DIV,  32'hFFFF_FF00, 32'h0, 32'h0, 32'h0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
    run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0);

    // Illegal op is not a request
    base = we_count;
    start_i = 1'b1; op_i = 3'd6; a_i = 32'h1; b_i = 32'h1;
    #1;
    chk("illegal_stall", stall_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("illegal_idle", {busy_o, 32'(we_count - base)}, 33'd0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'(($urandom_range(1, 15)));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(3'($urandom_range(0, 5)), ra, rb, $urandom, $urandom);
    end

    // Cancel in DIV_RUN cycle 10
    base = we_count;
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    chk("cancel_busy", busy_o, 1'b0);
    chk("cancel_stall", stall_o, 1'b0);
    repeat (40) @(negedge clk);
    chk("cancel_no_write", 32'(we_count - base), 32'd0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0);

    // Reset in DIV_RUN cycle 5
    base = we_count;
    start_i = 1'b1; op_i = OP_DIV; a_i = 32'hFFFF_F000; b_i = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_ctl", {busy_o, hilo_we_o, stall_o}, 3'b000);
    chk("rstmid_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_no_write", 32'(we_count - base), 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);

    chk("we_total", we_count, we_exp);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
